bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential binary-to-BCD converter feeding the 4-digit seven-segment multiplexer. It converts a 14-bit unsigned binary value into four packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. The 16-bit result goes straight onto the multiplexer's `num` input, so the display shows decimal instead of hex. The result register changes only when a conversion completes, so the display never shows intermediate values.

## Interface
- Parameters: none (input width fixed at 14 bits, output fixed at 4 digits).
- `clk` in 1: system clock, same domain as the display block.
- `rst` in 1: reset, synchronous, active-high.
- `din` in 14: unsigned binary value, 0..16383.
- `start` in 1: request one conversion of `din`; sampled only in IDLE.
- `auto` in 1: when 1, a conversion starts automatically in IDLE whenever `din` differs from the last captured value.
- `bcd` out 16: packed BCD result; `[3:0]` units, `[7:4]` tens, `[11:8]` hundreds, `[15:12]` thousands.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when `bcd`/`ovf` update.
- `ovf` out 1: last converted value exceeded 9999.

## Operation
- States: IDLE, CONV.
- IDLE:
  - Trigger is `start` | (`auto` & `din` != `last_din`).
  - On trigger, capture `din` into a 14-bit shift register and into `last_din`.
  - Clear the 16-bit BCD scratch register and set iteration counter to 0.
  - Register the compare `din` > 9999 as pending overflow.
  - Go to CONV.
- CONV, each cycle:
  - Every scratch digit >= 5 gets +3.
  - Then {scratch, shift} shifts left by 1.
  - Counter increments.
- Final iteration (counter = 13):
  - `bcd` <= corrected/shifted scratch, or 16'h9999 if pending overflow.
  - `ovf` <= pending overflow; `done` <= 1; go to IDLE.
- Triggers while in CONV are ignored. There is no queueing; a `din` change during CONV is picked up in IDLE by `auto`, or by a later `start`.
- `bcd` and `ovf` hold their previous values throughout CONV.
- Arithmetic: +3 correction is 4-bit and never overflows a digit, because digits are checked before the shift. Scratch is exactly 16 bits. Bits shifted out of the MSB are discarded; this only happens for overflow inputs, whose result is replaced by 16'h9999.
- Reset at any time, including mid-CONV:
  - state IDLE, `bcd` = 16'h0000, `busy` = 0, `done` = 0, `ovf` = 0.
  - `last_din` = 0, counter = 0, scratch = 0.
  - The aborted conversion produces no `done`.

## Timing
- Trigger seen in cycle N (IDLE) -> `busy` = 1 in cycles N+1..N+14.
- In cycle N+15: `busy` = 0, `done` = 1, `bcd`/`ovf` valid. Latency from trigger to `done` is 15 clocks.
- The earliest new trigger is cycle N+15, when the block is back in IDLE; back-to-back period is 15 clocks.
- `busy` and `done` are never high in the same cycle.
- `done` is high for exactly one cycle per completed conversion.
- With `auto` = 1 and constant `din`, exactly one conversion runs after each change, then the block stays idle.
- With `auto` = 1 and `din` = 0 after reset, no conversion runs; `bcd` is already 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then `din` = 1234, pulse `start` in cycle N -> `busy` high N+1..N+14; in N+15 `done` = 1, `bcd` = 16'h1234, `ovf` = 0.
- Boundary values via `start`: 0 -> 16'h0000; 9 -> 16'h0009; 10 -> 16'h0010; 9999 -> 16'h9999 with `ovf` = 0. Each completes in 15 clocks.
- `din` = 10000, and separately 16383, pulse `start` -> `bcd` = 16'h9999, `ovf` = 1. A following conversion of 42 -> `bcd` = 16'h0042, `ovf` = 0.
- Convert 500 via `start`, then pulse `start` with `din` = 777 in cycle N+5 -> request ignored. Single `done` in N+15 with `bcd` = 16'h0500; `bcd` stayed at its prior value through N+14.
- `auto` = 1, `start` = 0, step `din` 0 -> 256 -> hold -> 4095:
  - conversions yield 16'h0256, then 16'h4095;
  - exactly two `done` pulses;
  - no conversion while `din` holds.
- Convert 8888 to completion, start a conversion of 3210, assert `rst` in cycle N+7:
  - next cycle `bcd` = 0, `busy` = 0, `ovf` = 0;
  - no `done` pulse from the aborted conversion;
  - a fresh `start` with 3210 yields 16'h3210.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between a binary source and the bin2bcd_seq converter.
interface bin2bcd_seq_if;
    logic [13:0] din;
    logic        start;
    logic        auto;
    logic [15:0] bcd;
    logic        busy;
    logic        done;
    logic        ovf;

    modport master (
        output din, start, auto,
        input  bcd, busy, done, ovf
    );

    modport slave (
        input  din, start, auto,
        output bcd, busy, done, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble, one bit per clock).
module bin2bcd_seq (
    input logic          clk,
    input logic          rst,
    bin2bcd_seq_if.slave bus
);
    typedef enum logic {IDLE, CONV} state_t;

    state_t      state;
    logic [13:0] shift;
    logic [13:0] last_din;
    logic [15:0] scratch;
    logic [3:0]  count;
    logic        ovf_pend;

    logic [15:0] bcd_q;
    logic        busy_q;
    logic        done_q;
    logic        ovf_q;

    logic [15:0] corrected;
    logic        trigger;

    always_comb begin
        corrected = scratch;
        for (int unsigned i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                corrected[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    assign trigger = bus.start | (bus.auto & (bus.din != last_din));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            last_din <= '0;
            scratch  <= '0;
            count    <= '0;
            ovf_pend <= 1'b0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        shift    <= bus.din;
                        last_din <= bus.din;
                        scratch  <= '0;
                        count    <= '0;
                        ovf_pend <= (bus.din > 14'd9999);
                        busy_q   <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    // Correct digits first, then shift the combined {scratch, shift} left by one.
                    {scratch, shift} <= {corrected[14:0], shift, 1'b0};
                    count            <= count + 4'd1;
                    if (count == 4'd13) begin
                        bcd_q  <= ovf_pend ? 16'h9999 : {corrected[14:0], shift[13]};
                        ovf_q  <= ovf_pend;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
endmodule
